gift_subcells_seq: RTL and testbench

- Sequential forward GIFT SubCells unit for the gift_ise datapath; the encryption-direction counterpart of the existing inverse S-box.
- Accepts a full cipher state through a valid/ready handshake.
- Applies the forward GIFT S-box one byte (two nibbles) per cycle, in place.
- Returns the substituted state through a valid/ready handshake, so one 8-bit S-box instance is shared across the whole state.

---
 rtl/gift_pkg.sv | 27 ++
 rtl/gift_sbox.sv | 15 +
 rtl/gift_subcells_seq.sv | 80 ++++++++
 tb/tb_gift_subcells_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gift_pkg.sv
// rtl/gift_pkg.sv - shared GIFT tables, state widths and SubCells FSM encodings
package gift_pkg;

  // Nibble x occupies bits [4x+3:4x]
  localparam logic [63:0] GIFT_SBOX     = 64'he8057bd293f6c4a1;
  localparam logic [63:0] GIFT_INV_SBOX = 64'h5f93a17eb4c2680d;

  localparam int GIFT64_NB    = 8;
  localparam int GIFT128_NB   = 16;
  localparam int GIFT64_BITS  = 8 * GIFT64_NB;
  localparam int GIFT128_BITS = 8 * GIFT128_NB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } gift_fsm_e;

  function automatic logic [3:0] gift_sbox_nib(input logic [3:0] x);
    return GIFT_SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] gift_inv_sbox_nib(input logic [3:0] x);
    return GIFT_INV_SBOX[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/gift_sbox.sv
// rtl/gift_sbox.sv - forward GIFT S-box on one byte (two independent nibbles)
module gift_sbox
  import gift_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Both nibbles go through the same 4-bit table independently
  always_comb begin
    dout[3:0] = gift_sbox_nib(din[3:0]);
    dout[7:4] = gift_sbox_nib(din[7:4]);
  end

endmodule

// File: rtl/gift_subcells_seq.sv
// rtl/gift_subcells_seq.sv - byte-serial forward GIFT SubCells with valid/ready handshakes
module gift_subcells_seq
  import gift_pkg::*;
#(
  parameter int NB = 8,
  parameter int CW = $clog2(NB) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*NB-1:0] in_state,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*NB-1:0] out_state,
  output logic            busy
);

  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  gift_fsm_e       st, st_d;
  logic [CW-1:0]   idx;
  logic [8*NB-1:0] state_q;
  logic [7:0]      sbox_in;
  logic [7:0]      sbox_out;
  logic            accept;

  assign sbox_in   = state_q[8*idx +: 8];
  assign out_state = state_q;

  gift_sbox u_sbox (
    .din  (sbox_in),
    .dout (sbox_out)
  );

  // Next-state and handshake outputs; state only advances on the handshakes or the last byte
  always_comb begin
    st_d      = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (st)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) st_d = ST_SUB;
      end
      ST_SUB: begin
        busy = 1'b1;
        if (idx == LAST) st_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // FSM register plus in-place datapath: load on accept, one byte per SUB cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_IDLE;
      idx     <= '0;
      state_q <= '0;
    end else begin
      st <= st_d;
      if (accept) begin
        state_q <= in_state;
        idx     <= '0;
      end else if (st == ST_SUB) begin
        state_q[8*idx +: 8] <= sbox_out;
        if (idx != LAST) idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gift_subcells_seq.sv
// tb/tb_gift_subcells_seq.sv - directed table-driven bench for gift_subcells_seq
module tb_gift_subcells_seq;

  logic clk = 1'b0;
  logic rst;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [63:0] in_state8, out_state8;

  logic         in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [127:0] in_state16, out_state16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  gift_subcells_seq #(.NB(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_state  (in_state8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_state (out_state8),
    .busy      (busy8)
  );

  gift_subcells_seq #(.NB(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_state  (in_state16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_state (out_state16),
    .busy      (busy16)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] inv_bytes(input logic [63:0] s);
    logic [63:0] tbl;
    logic [63:0] r;
    tbl = 64'h5f93a17eb4c2680d;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = tbl[4*s[4*i +: 4] +: 4];
    return r;
  endfunction

  task automatic wait_valid8(output int n);
    n = 0;
    while (!out_valid8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run8(input string name, input logic [63:0] din, input logic [63:0] exp);
    int n;
    chk({name, " in_ready"}, {127'd0, in_ready8}, 128'd1);
    in_state8  = din;
    in_valid8  = 1'b1;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk({name, " busy"}, {127'd0, busy8}, 128'd1);
    wait_valid8(n);
    chk({name, " latency"}, 128'(n), 128'd8);
    chk({name, " out_state"}, {64'd0, out_state8}, {64'd0, exp});
    @(posedge clk); #1;
    chk({name, " in_ready after hs"}, {127'd0, in_ready8}, 128'd1);
    chk({name, " out_valid after hs"}, {127'd0, out_valid8}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{64'h0000000000000000, 64'h1111111111111111};
    vecs[1] = '{64'h0123456789abcdef, 64'h1a4c6f392db7508e};
    vecs[2] = '{64'hffffffffffffffff, 64'heeeeeeeeeeeeeeee};
    vecs[3] = '{64'hfedcba9876543210, 64'he8057bd293f6c4a1};

    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; in_state8 = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; in_state16 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset in_ready", {127'd0, in_ready8}, 128'd1);
    chk("reset out_valid", {127'd0, out_valid8}, 128'd0);
    chk("reset busy", {127'd0, busy8}, 128'd0);
    chk("reset out_state", {64'd0, out_state8}, 128'd0);
    chk("reset16 in_ready", {127'd0, in_ready16}, 128'd1);

    for (int i = 0; i < 4; i++) begin
      run8($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp);
      chk($sformatf("vec%0d roundtrip", i), {64'd0, inv_bytes(vecs[i].exp)}, {64'd0, vecs[i].din});
    end

    // Backpressure in DONE, with ignored in_valid pulse
    in_state8 = 64'hffffffffffffffff; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    wait_valid8(n);
    chk("bp latency", 128'(n), 128'd8);
    for (int c = 0; c < 5; c++) begin
      in_valid8 = (c == 2);
      in_state8 = 64'h0;
      @(posedge clk); #1;
      chk($sformatf("bp hold state c%0d", c), {64'd0, out_state8}, {64'd0, 64'heeeeeeeeeeeeeeee});
      chk($sformatf("bp hold valid c%0d", c), {127'd0, out_valid8}, 128'd1);
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready", {127'd0, in_ready8}, 128'd1);
    chk("bp release out_valid", {127'd0, out_valid8}, 128'd0);

    // Reset mid-SUB, with in_valid asserted alongside rst
    in_state8 = 64'h0123456789abcdef; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("partial sub", {64'd0, out_state8}, {64'd0, 64'h0123456789b7508e});
    rst = 1'b1; in_valid8 = 1'b1; in_state8 = 64'hffffffffffffffff;
    @(posedge clk); #1;
    rst = 1'b0; in_valid8 = 1'b0;
    chk("rst out_valid", {127'd0, out_valid8}, 128'd0);
    chk("rst in_ready", {127'd0, in_ready8}, 128'd1);
    chk("rst out_state", {64'd0, out_state8}, 128'd0);
    chk("rst busy", {127'd0, busy8}, 128'd0);
    run8("after rst", 64'h0, 64'h1111111111111111);

    // Back-to-back with in_valid held high
    in_state8 = 64'h0; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    wait_valid8(n);
    chk("b2b first latency", 128'(n), 128'd8);
    chk("b2b first out", {64'd0, out_state8}, {64'd0, 64'h1111111111111111});
    in_state8 = 64'hffffffffffffffff;
    @(posedge clk); #1;
    chk("b2b idle after hs", {127'd0, in_ready8}, 128'd1);
    @(posedge clk); #1;
    chk("b2b second accepted", {127'd0, busy8}, 128'd1);
    in_valid8 = 1'b0;
    wait_valid8(n);
    chk("b2b second latency", 128'(n), 128'd8);
    chk("b2b second out", {64'd0, out_state8}, {64'd0, 64'heeeeeeeeeeeeeeee});
    @(posedge clk); #1;

    // GIFT-128 instance
    in_state16 = 128'h00112233445566778899aabbccddeeff; in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("nb16 latency", 128'(n), 128'd16);
    chk("nb16 out_state", out_state16, 128'h11aa44cc66ff339922ddbb77550088ee);
    @(posedge clk); #1;
    chk("nb16 in_ready after hs", {127'd0, in_ready16}, 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
